// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep controller.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SAMPLE,
    ST_DONE
  } sweep_state_e;

  // A vector reads as 1 when strictly more than this many samples were 1.
  function automatic int unsigned maj_threshold(input int unsigned samples);
    return samples / 2;
  endfunction

endpackage

// File: rtl/tt_sweep_ctrl_majority_sampler.sv
// Counts ones on dut_out over a sample window and reports the majority,
// including the sample presented in the current cycle.
module majority_sampler
  import tt_sweep_pkg::*;
#(
  parameter int unsigned SAMPLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  input  logic bit_i,
  output logic majority_c_o
);

  localparam int unsigned CW  = $clog2(SAMPLES + 1);
  localparam int unsigned THR = maj_threshold(SAMPLES);

  logic [CW-1:0] ones_q;
  logic [CW:0]   ones_inc;

  assign ones_inc     = {1'b0, ones_q} + (CW + 1)'(bit_i);
  assign majority_c_o = en_i && (32'(ones_inc) > THR);

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      ones_q <= '0;
    end else if (en_i) begin
      ones_q <= CW'(ones_inc);
    end
  end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Walks every input vector of a small combinational circuit, majority-samples
// its output after a settle delay and compares the result with EXPECTED.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int unsigned          N_IN          = 3,
  parameter logic [(1<<N_IN)-1:0] EXPECTED      = 8'hF6,
  parameter int unsigned          SETTLE_CYCLES = 4,
  parameter int unsigned          SAMPLES       = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dut_out,
  output logic [N_IN-1:0]       dut_in,
  output logic                  busy,
  output logic                  done,
  output logic [(1<<N_IN)-1:0]  observed,
  output logic [(1<<N_IN)-1:0]  mismatch,
  output logic                  pass
);

  localparam int unsigned TT_W = 1 << N_IN;
  localparam int unsigned IW   = N_IN + 1;
  localparam int unsigned SW   = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned CW   = $clog2(SAMPLES + 1);

  sweep_state_e    state_q;
  logic [IW-1:0]   idx_q;
  logic [SW-1:0]   settle_q;
  logic [CW-1:0]   samp_q;
  logic [N_IN-1:0] dut_in_q;
  logic            busy_q;
  logic            done_q;
  logic [TT_W-1:0] obs_q;
  logic [TT_W-1:0] mis_q;
  logic            pass_q;

  logic            maj_c;
  logic [TT_W-1:0] obs_next_c;
  logic            last_settle_c;
  logic            last_samp_c;
  logic            last_vec_c;

  majority_sampler #(
    .SAMPLES (SAMPLES)
  ) u_sampler (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (state_q != ST_SAMPLE),
    .en_i         (state_q == ST_SAMPLE),
    .bit_i        (dut_out),
    .majority_c_o (maj_c)
  );

  assign last_settle_c = (settle_q == SW'(SETTLE_CYCLES - 1));
  assign last_samp_c   = (samp_q == CW'(SAMPLES - 1));
  assign last_vec_c    = (idx_q == IW'(TT_W - 1));

  // Truth table with the current vector's verdict merged in.
  always_comb begin
    obs_next_c = obs_q;
    obs_next_c[idx_q[N_IN-1:0]] = maj_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      samp_q   <= '0;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      obs_q    <= '0;
      mis_q    <= '0;
      pass_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q  <= ST_APPLY;
            idx_q    <= '0;
            settle_q <= '0;
            dut_in_q <= '0;
            busy_q   <= 1'b1;
            obs_q    <= '0;
            mis_q    <= '0;
            pass_q   <= 1'b0;
          end
        end
        ST_APPLY: begin
          if (last_settle_c) begin
            state_q <= ST_SAMPLE;
            samp_q  <= '0;
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        ST_SAMPLE: begin
          if (last_samp_c) begin
            obs_q <= obs_next_c;
            if (last_vec_c) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              mis_q   <= obs_next_c ^ EXPECTED;
              pass_q  <= (obs_next_c == EXPECTED);
            end else begin
              state_q  <= ST_APPLY;
              idx_q    <= idx_q + IW'(1);
              dut_in_q <= idx_q[N_IN-1:0] + N_IN'(1);
              settle_q <= '0;
            end
          end else begin
            samp_q <= samp_q + CW'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dut_in   = dut_in_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign observed = obs_q;
  assign mismatch = mis_q;
  assign pass     = pass_q;

endmodule
